// File: rtl/signdet_vote.sv
// Gesture vote filter: per-frame class tags feed a circular history whose per-class counts pick a stable gesture.
// Optional SIGNDET_VOTE_HOLD_EN keeps the previous gesture when no class reaches MIN_VOTES.
module signdet_vote #(
  parameter int NUM_CLASS = 10,
  parameter int HIST_LEN  = 8,
  parameter int MIN_VOTES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_init,
  input  logic        i_validp,
  input  logic [15:0] i_diff,
  input  logic [3:0]  i_max_idx,
  input  logic [15:0] i_thresh,
  output logic [3:0]  o_gesture,
  output logic [3:0]  o_votes,
  output logic        o_donep,
  output logic        o_changep,
  output logic        o_overflow
);

  localparam int PW = (HIST_LEN > 1) ? $clog2(HIST_LEN) : 1;
  localparam logic [3:0] NC   = 4'(NUM_CLASS);
  localparam logic [3:0] MV   = 4'(MIN_VOTES);
  localparam logic [3:0] NONE = 4'hF;

  typedef enum logic [1:0] {IDLE, UPDATE, SCAN, DECIDE} state_t;

  state_t state, state_nx;

  logic [3:0]    hist [HIST_LEN];
  logic [PW-1:0] wptr;
  logic [3:0]    cnt [16];
  logic [3:0]    cur_tag, pend_tag;
  logic          pend_vld;
  logic [3:0]    scan_idx, rd_cnt;
  logic [3:0]    best_cls, best_cnt;
  logic [3:0]    fin_cls, fin_cnt;
  logic [3:0]    new_gest, new_votes;
  logic [3:0]    tag_in, evict;
  logic          clr;

  assign clr    = reset | i_init;
  assign evict  = hist[wptr];
  assign tag_in = (i_max_idx < NC && i_diff >= i_thresh) ? i_max_idx : NONE;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (i_init) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (i_validp) state_nx = UPDATE;
        UPDATE:  state_nx = SCAN;
        SCAN:    if (scan_idx == NC) state_nx = DECIDE;
        DECIDE:  state_nx = (pend_vld | i_validp) ? UPDATE : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Counter reads are registered, so class k is compared one cycle after it is visited.
  always_comb begin
    fin_cls = best_cls;
    fin_cnt = best_cnt;
    if (scan_idx != 4'd0 && rd_cnt > best_cnt) begin
      fin_cls = scan_idx - 4'd1;
      fin_cnt = rd_cnt;
    end
  end

  always_comb begin
    new_gest  = fin_cls;
    new_votes = fin_cnt;
    if (fin_cnt < MV) begin
`ifdef SIGNDET_VOTE_HOLD_EN
      new_gest  = o_gesture;
      new_votes = (o_gesture == NONE) ? 4'd0 : cnt[o_gesture];
`else
      new_gest  = NONE;
      new_votes = 4'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < HIST_LEN; i++) hist[i] <= NONE;
      for (int c = 0; c < 16; c++) cnt[c] <= 4'd0;
      wptr       <= '0;
      cur_tag    <= NONE;
      pend_tag   <= NONE;
      pend_vld   <= 1'b0;
      scan_idx   <= 4'd0;
      rd_cnt     <= 4'd0;
      best_cls   <= NONE;
      best_cnt   <= 4'd0;
      o_gesture  <= NONE;
      o_votes    <= 4'd0;
      o_donep    <= 1'b0;
      o_changep  <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_donep   <= 1'b0;
      o_changep <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_validp) cur_tag <= tag_in;
        end
        UPDATE: begin
          hist[wptr] <= cur_tag;
          wptr       <= wptr + 1'b1;
          for (int c = 0; c < NUM_CLASS; c++)
            cnt[c] <= cnt[c] - {3'b0, evict == 4'(c)}
                             + {3'b0, cur_tag == 4'(c)};
          scan_idx <= 4'd0;
          best_cls <= NONE;
          best_cnt <= 4'd0;
        end
        SCAN: begin
          rd_cnt   <= cnt[scan_idx];
          scan_idx <= scan_idx + 4'd1;
          best_cls <= fin_cls;
          best_cnt <= fin_cnt;
          if (scan_idx == NC) begin
            o_gesture <= new_gest;
            o_votes   <= new_votes;
            o_donep   <= 1'b1;
            o_changep <= (new_gest != o_gesture);
          end
        end
        DECIDE: begin
          if (pend_vld)      cur_tag <= pend_tag;
          else if (i_validp) cur_tag <= tag_in;
        end
        default: ;
      endcase
      // A frame arriving in DECIDE reuses the slot being drained.
      if (i_validp && state != IDLE) begin
        if (state == DECIDE) begin
          if (pend_vld) pend_tag <= tag_in;
        end else if (!pend_vld) begin
          pend_tag <= tag_in;
          pend_vld <= 1'b1;
        end else begin
          o_overflow <= 1'b1;
        end
      end else if (state == DECIDE) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule
